// File: rtl/senha_pkg.sv
// Shared types and constants for the password-lock sequencer.
// Covers state encoding, key codes, blank code and letter messages.
package senha_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_PROG,
    ST_FAIL,
    ST_LOCKED
  } state_e;

  localparam logic [3:0] KEY_CLR   = 4'hA;
  localparam logic [3:0] KEY_ENT   = 4'hB;
  localparam logic [3:0] KEY_PRG   = 4'hC;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam logic [2:0] LTR_NONE = 3'd0;
  localparam logic [2:0] LTR_O    = 3'd1;
  localparam logic [2:0] LTR_P    = 3'd2;
  localparam logic [2:0] LTR_E    = 3'd3;
  localparam logic [2:0] LTR_N    = 3'd4;
  localparam logic [2:0] LTR_R    = 3'd5;

  // Messages are packed slot3..slot0, leftmost letter in the MSBs.
  localparam logic [11:0] MSG_OPEN = {LTR_O, LTR_P, LTR_E, LTR_N};
  localparam logic [11:0] MSG_ERRO = {LTR_E, LTR_R, LTR_R, LTR_O};

  function automatic logic is_digit(logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/senha_buf.sv
// Digit entry buffer plus stored password for the lock sequencer.
// Shifts digits in at slot 0, tracks fill count and compares against the password.
module senha_buf
  import senha_pkg::*;
#(
  parameter int unsigned NDIG = 4,
  localparam int unsigned CW  = $clog2(NDIG + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                push,
  input  logic [3:0]          din,
  input  logic                load,
  output logic [4*NDIG-1:0]   dig_nxt,
  output logic [CW-1:0]       cnt_nxt,
  output logic [CW-1:0]       cnt,
  output logic                eq
);

  logic [4*NDIG-1:0] dig_q, pw_q, pw_d, pw_init;
  logic [CW-1:0]     cnt_q;

  // Power-on password reads 1,2,3,...,NDIG from the leftmost slot.
  always_comb begin
    pw_init = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      pw_init[4*i +: 4] = 4'((int'(NDIG) - i) % 10);
    end
  end

  always_comb begin
    dig_nxt = dig_q;
    cnt_nxt = cnt_q;
    pw_d    = pw_q;
    if (load) pw_d = dig_q;
    if (clr) begin
      dig_nxt = '0;
      cnt_nxt = '0;
    end else if (push && (cnt_q < CW'(NDIG))) begin
      dig_nxt = {dig_q[4*NDIG-5:0], din};
      cnt_nxt = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q <= '0;
      cnt_q <= '0;
      pw_q  <= pw_init;
    end else begin
      dig_q <= dig_nxt;
      cnt_q <= cnt_nxt;
      pw_q  <= pw_d;
    end
  end

  assign cnt = cnt_q;
  assign eq  = (dig_q == pw_q);

endmodule

// File: rtl/senha_ctrl.sv
// Password-lock sequencer: key handling FSM, retry/lockout timing and registered
// per-slot display codes for the BCD and letter decoders.
module senha_ctrl
  import senha_pkg::*;
#(
  parameter int unsigned NDIG      = 4,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned SHOW_CYC  = 50,
  parameter int unsigned LOCK_CYC  = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_val,
  output logic [4*NDIG-1:0]   disp_bcd,
  output logic [3*NDIG-1:0]   disp_ltr,
  output logic [NDIG-1:0]     disp_sel,
  output logic                unlocked,
  output logic                alarm
);

  localparam int unsigned CW = $clog2(NDIG + 1);
  localparam int unsigned TW = $clog2(LOCK_CYC + 1);

  state_e            state_q, state_d;
  logic [2:0]        tries_q, tries_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              push, clr, load, eq, full, last_try;
  logic              k_dig, k_clr, k_ent, k_prg;
  logic [4*NDIG-1:0] dig_nxt, bcd_d;
  logic [3*NDIG-1:0] ltr_d;
  logic [NDIG-1:0]   sel_d;
  logic [CW-1:0]     cnt, cnt_nxt;

  senha_buf #(
    .NDIG(NDIG)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .push   (push),
    .din    (key_val),
    .load   (load),
    .dig_nxt(dig_nxt),
    .cnt_nxt(cnt_nxt),
    .cnt    (cnt),
    .eq     (eq)
  );

  assign k_dig    = key_valid && is_digit(key_val);
  assign k_clr    = key_valid && (key_val == KEY_CLR);
  assign k_ent    = key_valid && (key_val == KEY_ENT);
  assign k_prg    = key_valid && (key_val == KEY_PRG);
  assign full     = (cnt == CW'(NDIG));
  assign last_try = (({1'b0, tries_q} + 4'd1) >= 4'(MAX_TRIES));

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    tmr_d   = tmr_q;
    push    = 1'b0;
    clr     = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        push = k_dig;
        clr  = k_clr;
        if (k_ent && full) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        clr = 1'b1;
        if (eq) begin
          state_d = ST_OPEN;
          tries_d = '0;
        end else begin
          tries_d = tries_q + 3'd1;
          if (last_try) begin
            state_d = ST_LOCKED;
            tmr_d   = TW'(LOCK_CYC - 1);
          end else begin
            state_d = ST_FAIL;
            tmr_d   = TW'(SHOW_CYC - 1);
          end
        end
      end
      ST_OPEN: begin
        if (k_ent || k_clr) state_d = ST_ENTRY;
        else if (k_prg)     state_d = ST_PROG;
      end
      ST_PROG: begin
        push = k_dig;
        if (k_ent && full) begin
          load    = 1'b1;
          clr     = 1'b1;
          state_d = ST_OPEN;
        end else if (k_prg) begin
          clr     = 1'b1;
          state_d = ST_OPEN;
        end else begin
          clr = k_clr;
        end
      end
      ST_FAIL, ST_LOCKED: begin
        if (tmr_q == '0) begin
          state_d = ST_ENTRY;
          if (state_q == ST_LOCKED) tries_d = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // Display is decoded from next-state values so it updates on the accepting edge.
  always_comb begin
    bcd_d = {NDIG{BCD_BLANK}};
    ltr_d = '0;
    sel_d = '0;
    case (state_d)
      ST_OPEN: begin
        sel_d        = '1;
        ltr_d[11:0]  = MSG_OPEN;
      end
      ST_FAIL, ST_LOCKED: begin
        sel_d        = '1;
        ltr_d[11:0]  = MSG_ERRO;
      end
      default: begin
        for (int i = 0; i < int'(NDIG); i++) begin
          if (CW'(i) < cnt_nxt) bcd_d[4*i +: 4] = dig_nxt[4*i +: 4];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ENTRY;
      tries_q  <= '0;
      tmr_q    <= '0;
      disp_bcd <= {NDIG{BCD_BLANK}};
      disp_ltr <= '0;
      disp_sel <= '0;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      tmr_q    <= tmr_d;
      disp_bcd <= bcd_d;
      disp_ltr <= ltr_d;
      disp_sel <= sel_d;
      unlocked <= (state_d == ST_OPEN) || (state_d == ST_PROG);
      alarm    <= (state_d == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_senha_ctrl.sv
// Directed bench for senha_ctrl with default parameters (NDIG=4, MAX_TRIES=3,
// SHOW_CYC=50, LOCK_CYC=500). Inputs change on negedge, outputs sampled on negedge.
module tb_senha_ctrl;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_val;
  logic [15:0] disp_bcd;
  logic [11:0] disp_ltr;
  logic [3:0]  disp_sel;
  logic        unlocked;
  logic        alarm;

  int n_total = 0;
  int n_bad   = 0;
  int n;

  localparam logic [11:0] OPEN_CODE = 12'h29C;  // O,P,E,N = 1,2,3,4
  localparam logic [11:0] ERRO_CODE = 12'h769;  // E,R,R,O = 3,5,5,1

  senha_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_val  (key_val),
    .disp_bcd (disp_bcd),
    .disp_ltr (disp_ltr),
    .disp_sel (disp_sel),
    .unlocked (unlocked),
    .alarm    (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] v);
    @(negedge clk);
    key_valid = 1'b1;
    key_val   = v;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
  endtask

  // Holds a key strobe high and counts cycles spent in the message/alarm state.
  task automatic hold_len(input logic use_alarm, input logic [3:0] code, output int cnt);
    cnt       = 0;
    key_valid = 1'b1;
    key_val   = code;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (use_alarm ? alarm : (disp_sel == 4'hF)) cnt++;
      else break;
    end
    key_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_val = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_bcd", disp_bcd, 16'hFFFF);
    check("rst_sel", disp_sel, 4'h0);
    check("rst_ltr", disp_ltr, 12'h0);
    check("rst_unl", unlocked, 1'b0);
    check("rst_alarm", alarm, 1'b0);

    // 1: correct default password
    send4(4'd1, 4'd2, 4'd3, 4'd4);
    check("t1_entry_bcd", disp_bcd, 16'h1234);
    send(4'hB);
    check("t1_check_unl", unlocked, 1'b0);
    @(negedge clk);
    check("t1_open_unl", unlocked, 1'b1);
    check("t1_open_sel", disp_sel, 4'hF);
    check("t1_open_ltr", disp_ltr, OPEN_CODE);
    send(4'hB);
    check("t1_relock", unlocked, 1'b0);
    check("t1_relock_bcd", disp_bcd, 16'hFFFF);

    // 2: short enter ignored, right alignment, clear
    send(4'd1); send(4'd2); send(4'hB);
    check("t2_short_ent", disp_bcd, 16'hFF12);
    check("t2_short_sel", disp_sel, 4'h0);
    send(4'd5);
    check("t2_digit5", disp_bcd, 16'hF125);
    send(4'hA);
    check("t2_clear", disp_bcd, 16'hFFFF);

    // 5: overflow digits dropped, invalid codes ignored
    send4(4'd1, 4'd2, 4'd3, 4'd4); send(4'd5); send(4'd6);
    check("t5_overflow", disp_bcd, 16'h1234);
    send(4'hE); send(4'hF);
    check("t5_invalid", disp_bcd, 16'h1234);
    send(4'hA);

    // 3: two FAILs, then lockout
    send4(4'd9, 4'd9, 4'd9, 4'd9); send(4'hB);
    hold_len(1'b0, 4'd1, n);
    check("t3_fail1_len", n, 50);
    check("t3_fail1_keys", disp_bcd, 16'hFFFF);
    send4(4'd9, 4'd9, 4'd9, 4'd9); send(4'hB);
    @(negedge clk);
    check("t3_fail2_ltr", disp_ltr, ERRO_CODE);
    check("t3_fail2_alarm", alarm, 1'b0);
    hold_len(1'b0, 4'hD, n);
    check("t3_fail2_len", n, 49);
    send4(4'd9, 4'd9, 4'd9, 4'd9); send(4'hB);
    hold_len(1'b1, 4'hA, n);
    check("t3_lock_len", n, 500);
    check("t3_lock_exit_bcd", disp_bcd, 16'hFFFF);
    check("t3_lock_exit_sel", disp_sel, 4'h0);
    // tries cleared: a fourth wrong entry must give FAIL, not lockout
    send4(4'd9, 4'd9, 4'd9, 4'd9); send(4'hB);
    @(negedge clk);
    check("t3_tries_reset", alarm, 1'b0);
    check("t3_tries_fail", disp_ltr, ERRO_CODE);
    hold_len(1'b0, 4'hD, n);
    check("t3_fail3_len", n, 49);

    // 4: program new password, abort path, old password rejected
    send4(4'd1, 4'd2, 4'd3, 4'd4); send(4'hB);
    @(negedge clk);
    send(4'hC);
    check("t4_prog_unl", unlocked, 1'b1);
    check("t4_prog_sel", disp_sel, 4'h0);
    send4(4'd5, 4'd6, 4'd7, 4'd8);
    check("t4_prog_bcd", disp_bcd, 16'h5678);
    send(4'hB);
    check("t4_prog_done", disp_sel, 4'hF);
    check("t4_prog_ltr", disp_ltr, OPEN_CODE);
    send(4'hC); send(4'd9); send(4'hC);
    check("t4_abort_open", disp_ltr, OPEN_CODE);
    send(4'hB);
    check("t4_relock", unlocked, 1'b0);
    send4(4'd1, 4'd2, 4'd3, 4'd4); send(4'hB);
    @(negedge clk);
    check("t4_old_pw", disp_ltr, ERRO_CODE);
    hold_len(1'b0, 4'hD, n);
    check("t4_fail_len", n, 49);
    send4(4'd5, 4'd6, 4'd7, 4'd8); send(4'hB);
    @(negedge clk);
    check("t4_new_pw", unlocked, 1'b1);
    send(4'hA);

    // 6: reset during lockout restores defaults
    for (int t = 0; t < 2; t++) begin
      send4(4'd0, 4'd0, 4'd0, 4'd0); send(4'hB);
      hold_len(1'b0, 4'hD, n);
    end
    send4(4'd0, 4'd0, 4'd0, 4'd0); send(4'hB);
    repeat (10) @(negedge clk);
    check("t6_locked", alarm, 1'b1);
    rst = 1'b1; key_valid = 1'b1; key_val = 4'd1;
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0;
    check("t6_alarm", alarm, 1'b0);
    check("t6_bcd", disp_bcd, 16'hFFFF);
    check("t6_sel", disp_sel, 4'h0);
    send4(4'd1, 4'd2, 4'd3, 4'd4); send(4'hB);
    @(negedge clk);
    check("t6_pw_default", unlocked, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
